// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the EX-stage forwarding/hazard controller: mux select
// codes, the shadowed pipeline-stage record and the stall FSM states.
package fwd_pkg;

  // Records are sized for the widest register index any instance may use;
  // narrower indices are zero-extended, which preserves equality and x0 tests.
  localparam int FWD_AW_MAX = 8;

  localparam logic [1:0] FWD_SEL_REG   = 2'b00;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b01;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [FWD_AW_MAX-1:0] rs1;
    logic [FWD_AW_MAX-1:0] rs2;
    logic [FWD_AW_MAX-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_rec_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

  // True when the stage will write a non-x0 register that matches rs.
  function automatic logic rec_writes(input stage_rec_t r,
                                      input logic [FWD_AW_MAX-1:0] rs);
    return r.valid && r.regwrite && (r.rd != '0) && (r.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Priority compare for one operand forwarding mux: EX/MEM beats MEM/WB,
// an invalid consumer or a miss selects the register file.
module fwd_sel_unit
  import fwd_pkg::*;
(
  input  logic                  rs_valid,
  input  logic [FWD_AW_MAX-1:0] rs,
  input  stage_rec_t            ex_mem,
  input  stage_rec_t            mem_wb,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_SEL_REG;
    if (rs_valid) begin
      if (rec_writes(ex_mem, rs))      sel = FWD_SEL_EXMEM;
      else if (rec_writes(mem_wb, rs)) sel = FWD_SEL_MEMWB;
    end
  end

  // Source fields and memread ride along in the record but play no part here.
  logic unused_fields;
  assign unused_fields = ^{ex_mem.rs1, ex_mem.rs2, ex_mem.memread,
                           mem_wb.rs1, mem_wb.rs2, mem_wb.memread};

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall/bubble controller.
// Optional perf counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,  // must not exceed FWD_AW_MAX
  parameter int STALL_CYCLES = 1   // 1..3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           fwd_cnt_o
);

  localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES - 1);

  logic [FWD_AW_MAX-1:0] rs1_x, rs2_x, rd_x;
  assign rs1_x = FWD_AW_MAX'(id_rs1_i);
  assign rs2_x = FWD_AW_MAX'(id_rs2_i);
  assign rd_x  = FWD_AW_MAX'(id_rd_i);

  stage_rec_t id_rec, id_ex_q, ex_mem_q, mem_wb_q;
  fsm_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hazard;

  assign hazard = id_ex_q.valid && id_ex_q.memread && (id_ex_q.rd != '0) &&
                  id_valid_i && ((id_ex_q.rd == rs1_x) || (id_ex_q.rd == rs2_x));

  // flush_i outranks everything: it kills ID and aborts any stall in progress.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          bubble_o = 1'b1;
        end else if (hazard) begin
          stall_o  = 1'b1;
          bubble_o = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = ST_STALL;
            cnt_d   = STALL_INIT;
          end
        end
      end
      default: begin
        bubble_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    id_rec          = '0;
    id_rec.valid    = id_valid_i && !stall_o && !flush_i;
    id_rec.rs1      = rs1_x;
    id_rec.rs2      = rs2_x;
    id_rec.rd       = rd_x;
    id_rec.regwrite = id_regwrite_i;
    id_rec.memread  = id_memread_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      id_ex_q  <= id_rec;
      ex_mem_q <= id_ex_q;
      mem_wb_q <= ex_mem_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  fwd_sel_unit u_sel_a (
    .rs_valid (id_ex_q.valid),
    .rs       (id_ex_q.rs1),
    .ex_mem   (ex_mem_q),
    .mem_wb   (mem_wb_q),
    .sel      (fwd_a_o)
  );

  fwd_sel_unit u_sel_b (
    .rs_valid (id_ex_q.valid),
    .rs       (id_ex_q.rs2),
    .ex_mem   (ex_mem_q),
    .mem_wb   (mem_wb_q),
    .sel      (fwd_b_o)
  );

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (((fwd_a_o != FWD_SEL_REG) || (fwd_b_o != FWD_SEL_REG)) && !(&fwd_cnt_q))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: two instances (STALL_CYCLES 1 and 2)
// share one ID stream; each scenario checks the instance(s) it targets.
module tb_fwd_hazard_ctrl;

`ifdef FWD_HAZARD_PERF_EN
  localparam logic [31:0] PERF = 32'd1;
`else
  localparam logic [31:0] PERF = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_regwrite, id_memread, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic        st [2];
  logic        bb [2];
  logic [31:0] scnt [2];
  logic [31:0] fcnt [2];

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .flush_i(flush), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]),
    .stall_o(st[0]), .bubble_o(bb[0]), .stall_cnt_o(scnt[0]), .fwd_cnt_o(fcnt[0])
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .flush_i(flush), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]),
    .stall_o(st[1]), .bubble_o(bb[1]), .stall_cnt_o(scnt[1]), .fwd_cnt_o(fcnt[1])
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, fl;
  } ins_t;

  typedef struct {
    int         dut;
    logic [5:0] v;   // {fwd_a, fwd_b, stall, bubble}
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic ins_t mk(input logic v, input logic [4:0] rs1, rs2, rd,
                              input logic rw, mr, fl);
    ins_t i;
    i = '{v: v, rs1: rs1, rs2: rs2, rd: rd, rw: rw, mr: mr, fl: fl};
    return i;
  endfunction

  function automatic logic [5:0] obs(input int d);
    return {fa[d], fb[d], st[d], bb[d]};
  endfunction

  task automatic apply(input ins_t i);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_regwrite = i.rw; id_memread = i.mr; flush = i.fl;
  endtask

  task automatic push(input int mask, input logic [5:0] e1, e2, input string tag);
    exp_t e;
    e.tag = tag;
    if (mask[0]) begin e.dut = 0; e.v = e1; exp_q.push_back(e); end
    if (mask[1]) begin e.dut = 1; e.v = e2; exp_q.push_back(e); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply('0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam ins_t NOP = '0;

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    push(3, 6'b0, 6'b0, "reset_out");
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (obs(e.dut) !== e.v) begin
        miscompares++;
        $display("FAIL %s dut%0d: got %b want %b", e.tag, e.dut + 1, obs(e.dut), e.v);
      end
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({scnt[d], fcnt[d]} !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_cnt dut%0d: got %h/%h want 0/0", d + 1, scnt[d], fcnt[d]);
      end
    end
  endtask

  task automatic test_fwd_exmem();
    ins_t prog[4];
    logic [5:0] ex[4];
    prog = '{mk(1,1,2,5,1,0,0), mk(1,5,1,6,1,0,0), NOP, NOP};
    ex   = '{6'b00_00_00, 6'b00_00_00, 6'b10_00_00, 6'b00_00_00};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1 apply(prog[c]);
      push(3, ex[c], ex[c], "fwd_exmem");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
  endtask

  task automatic test_fwd_memwb();
    ins_t prog[5];
    logic [5:0] ex[5];
    prog = '{mk(1,1,2,5,1,0,0), NOP, mk(1,2,5,7,1,0,0), NOP, NOP};
    ex   = '{6'b0, 6'b0, 6'b0, 6'b00_01_00, 6'b0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 apply(prog[c]);
      push(3, ex[c], ex[c], "fwd_memwb");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
  endtask

  // x0 destination, and a non-writing producer, must never forward.
  task automatic test_no_fwd();
    ins_t prog[6];
    prog = '{mk(1,1,2,0,1,0,0), mk(1,0,1,6,1,0,0), mk(1,1,2,5,0,0,0),
             mk(1,5,5,6,1,0,0), NOP, NOP};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 apply(prog[c]);
      push(3, 6'b0, 6'b0, "no_fwd");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
  endtask

  task automatic test_priority();
    ins_t prog[5];
    logic [5:0] ex[5];
    prog = '{mk(1,1,2,5,1,0,0), mk(1,3,4,5,1,0,0), mk(1,5,5,8,1,0,0), NOP, NOP};
    ex   = '{6'b0, 6'b0, 6'b0, 6'b10_10_00, 6'b0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 apply(prog[c]);
      push(3, ex[c], ex[c], "priority");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
  endtask

  task automatic test_load_use_1();
    ins_t prog[5];
    logic [5:0] ex[5];
    prog = '{mk(1,1,0,4,1,1,0), mk(1,4,2,9,1,0,0), mk(1,4,2,9,1,0,0), NOP, NOP};
    ex   = '{6'b0, 6'b00_00_11, 6'b0, 6'b01_00_00, 6'b0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 apply(prog[c]);
      push(1, ex[c], 6'b0, "load_use_1");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
    vectors++;
    if (scnt[0] !== PERF) begin
      miscompares++;
      $display("FAIL stall_cnt dut1: got %0d want %0d", scnt[0], PERF);
    end
    vectors++;
    if (fcnt[0] !== PERF) begin
      miscompares++;
      $display("FAIL fwd_cnt dut1: got %0d want %0d", fcnt[0], PERF);
    end
  endtask

  task automatic test_load_use_2();
    ins_t prog[6];
    logic [5:0] ex[6];
    prog = '{mk(1,1,0,4,1,1,0), mk(1,4,2,9,1,0,0), mk(1,4,2,9,1,0,0),
             mk(1,4,2,9,1,0,0), NOP, NOP};
    ex   = '{6'b0, 6'b00_00_11, 6'b00_00_11, 6'b0, 6'b0, 6'b0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 apply(prog[c]);
      push(2, 6'b0, ex[c], "load_use_2");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
  endtask

  // Flush in IDLE with a pending hazard (both), then flush inside STALL (dut2).
  task automatic test_flush();
    ins_t pa[4], pb[5];
    logic [5:0] ea[4], eb[5];
    pa = '{mk(1,1,0,4,1,1,0), mk(1,4,2,9,1,0,1), NOP, NOP};
    ea = '{6'b0, 6'b00_00_01, 6'b0, 6'b0};
    pb = '{mk(1,1,0,4,1,1,0), mk(1,4,2,9,1,0,0), mk(1,4,2,9,1,0,1),
           mk(1,4,2,9,1,0,0), NOP};
    eb = '{6'b0, 6'b00_00_11, 6'b00_00_01, 6'b0, 6'b0};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 4) do_reset();
      @(posedge clk); #1 apply(c < 4 ? pa[c] : pb[c-4]);
      if (c < 4) push(3, ea[c], ea[c], "flush_idle");
      else       push(2, 6'b0, eb[c-4], "flush_stall");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ins_t pa[7], pb[8];
    logic [5:0] ea[7], eb[8];
    pa = '{mk(1,1,0,4,1,1,0), mk(1,4,0,5,1,1,0), mk(1,4,0,5,1,1,0),
           mk(1,5,0,6,1,0,0), mk(1,5,0,6,1,0,0), NOP, NOP};
    ea = '{6'b0, 6'b00_00_11, 6'b0, 6'b01_00_11, 6'b0, 6'b01_00_00, 6'b0};
    pb = '{mk(1,1,0,4,1,1,0), mk(1,4,0,5,1,1,0), mk(1,4,0,5,1,1,0),
           mk(1,4,0,5,1,1,0), mk(1,5,0,6,1,0,0), mk(1,5,0,6,1,0,0),
           mk(1,5,0,6,1,0,0), NOP};
    eb = '{6'b0, 6'b00_00_11, 6'b00_00_11, 6'b0, 6'b00_00_11, 6'b00_00_11,
           6'b0, 6'b0};
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c == 7) do_reset();
      @(posedge clk); #1 apply(c < 7 ? pa[c] : pb[c-7]);
      if (c < 7) push(1, ea[c], 6'b0, "b2b_1");
      else       push(2, 6'b0, eb[c-7], "b2b_2");
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    ins_t prog[4];
    logic [5:0] ex[4];
    prog = '{mk(1,1,0,4,1,1,0), mk(1,4,2,9,1,0,0), mk(1,4,2,9,1,0,0), NOP};
    ex   = '{6'b0, 6'b00_00_11, 6'b0, 6'b0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1 apply(prog[c]);
      push(3, ex[c], ex[c], "mid_stall");
      @(negedge clk);
      if (c == 1) begin
        while (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          vectors++;
          if (obs(e.dut) !== e.v) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
          end
        end
        #2 rst_n = 1'b0;
        push(3, 6'b0, 6'b0, "async_rst");
        #1;
      end
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (obs(e.dut) !== e.v) begin
          miscompares++;
          $display("FAIL %s dut%0d cyc%0d: got %b want %b", e.tag, e.dut + 1, c, obs(e.dut), e.v);
        end
      end
      if (c == 1) begin
        vectors++;
        if (scnt[1] !== 32'd0) begin
          miscompares++;
          $display("FAIL rst_stall_cnt dut2: got %0d want 0", scnt[1]);
        end
        #1 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_no_fwd();
    test_priority();
    test_load_use_1();
    test_load_use_2();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the EX-stage forwarding muxes of the 5-stage pipeline.
- Shadows the rd/regwrite/memread state of ID/EX, EX/MEM and MEM/WB internally.
- Drives the 2-bit select of both operand forwarding muxes (A and B).
- Detects load-use hazards; holds PC/IF-ID and injects ID/EX bubbles for a programmable number of cycles.

Parameters:
- REG_ADDR_W, 5, register index width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i  in  REG_ADDR_W  ID source 1.
- id_rs2_i  in  REG_ADDR_W  ID source 2.
- id_rd_i  in  REG_ADDR_W  ID destination.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  branch taken; kill ID instruction.
- fwd_a_o  out  2  operand A mux select.
- fwd_b_o  out  2  operand B mux select.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  zero ID/EX controls this cycle.
- stall_cnt_o  out  32  stall-cycle counter (optional feature).
- fwd_cnt_o  out  32  forwarding-event counter (optional feature).

Behaviour:
- Select encoding (matches mux): 00 register file, 01 MEM/WB (memory/writeback data), 10 EX/MEM (ALU result), 11 never driven.
- Reset (rst_i low, async): all stage records invalid, FSM IDLE, counters 0. Resulting outputs: fwd_a_o=fwd_b_o=00, stall_o=0, bubble_o=0.
- Reset mid-stall aborts the stall immediately.
- Stage records, each {valid, rs1, rs2, rd, regwrite, memread}, advance every posedge:
  - MEM/WB <= EX/MEM; EX/MEM <= ID/EX.
  - ID/EX <= ID inputs, unless stall_o, flush_i or !id_valid_i, in which case ID/EX is invalid (bubble).
- Forwarding (combinational from registered state, zero latency), per operand, rs = ID/EX.rs1 (A) or ID/EX.rs2 (B):
  - 10 if EX/MEM valid && regwrite && rd!=0 && rd==rs.
  - Else 01 if MEM/WB valid && regwrite && rd!=0 && rd==rs.
  - Else 00.
  - Invalid ID/EX gives 00; x0 is never forwarded; EX/MEM beats MEM/WB.
- Hazard detect (combinational): ID/EX valid && memread && rd!=0 && id_valid_i && (rd==id_rs1_i || rd==id_rs2_i).
- FSM IDLE/STALL with 2-bit counter cnt:
  - IDLE: stall_o = bubble_o = hazard && !flush_i. On hazard && !flush_i: if STALL_CYCLES>1 go STALL with cnt=STALL_CYCLES-1, else stay IDLE.
  - STALL: stall_o=bubble_o=1, cnt decrements each cycle; leave to IDLE when cnt reaches 1 (last stall cycle).
- Each hazard therefore gives exactly STALL_CYCLES consecutive stall cycles.
- flush_i has priority over everything:
  - In IDLE: stall_o=0, bubble_o=1.
  - In STALL: stall aborted, next state IDLE, bubble_o=1 this cycle.
- Back-to-back hazards: a new hazard detected in IDLE right after a stall ends starts a fresh stall.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined:
  - stall_cnt_o increments on every cycle with stall_o=1.
  - fwd_cnt_o increments once per cycle in which either select is non-zero.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- Undefined: both ports are present and tied to 0; no counter flops are built.

Decomposition:
- Package fwd_pkg holds:
  - FWD_SEL_REG=2'b00, FWD_SEL_MEMWB=2'b01, FWD_SEL_EXMEM=2'b10.
  - Typedef stage_rec_t for the stage record.
  - FSM state enum {ST_IDLE, ST_STALL}.
- Sub-module fwd_sel_unit: pure priority compare (rs, EX/MEM record, MEM/WB record -> 2-bit select), instantiated twice for A and B.

Test Plan:
- add x5 then add x6,x5,x1 on consecutive cycles -> when add x6 reaches EX, fwd_a_o=10, fwd_b_o=00.
- add x5; nop; sub x7,x2,x5 -> fwd_b_o=01 at sub EX; the add x5 / add x6 case with x5 replaced by x0 -> both selects 00.
- Priority: add x5; add x5; or x8,x5,x5 -> fwd_a_o=fwd_b_o=10 (EX/MEM wins).
- Load-use, STALL_CYCLES=1: lw x4,0(x1); add x9,x4,x2 -> one cycle stall_o=1/bubble_o=1, then add EX sees fwd_a_o=01.
- STALL_CYCLES=2: same sequence -> exactly 2 stall cycles, then fwd_a_o=00.
- Same sequence with flush_i=1 during the stall cycle -> stall_o=0 that cycle, bubble_o=1, FSM IDLE.
- Reset pulse (rst_i low) mid-stall -> all outputs 0 asynchronously.
- With FWD_HAZARD_PERF_EN, after the first load-use case (STALL_CYCLES=1) -> stall_cnt_o=1, fwd_cnt_o=1.
